mont_arbiter: RTL and testbench



---
 rtl/mont_arbiter.sv | 137 +++++++++++++
 tb/tb_mont_arbiter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/mont_arbiter.sv
// Round-robin arbiter sharing one Montgomery multiplier between two requesters.
// Optional watchdog enabled by defining MONT_ARB_TIMEOUT_EN.
module mont_arbiter #(
  parameter int WIDTH          = 256,
  parameter int TIMEOUT_CYCLES = 300
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [1:0]       i_req_valid,
  input  logic [WIDTH-1:0] i_req_a0,
  input  logic [WIDTH-1:0] i_req_b0,
  input  logic [WIDTH-1:0] i_req_a1,
  input  logic [WIDTH-1:0] i_req_b1,
  output logic [1:0]       o_req_ready,
  output logic [1:0]       o_rsp_valid,
  output logic [WIDTH-1:0] o_rsp_result,
  output logic             o_rsp_err,
  output logic             o_mont_start,
  output logic [WIDTH-1:0] o_mont_a,
  output logic [WIDTH-1:0] o_mont_b,
  input  logic [WIDTH-1:0] i_mont_result,
  input  logic             i_mont_finished
);

  typedef enum logic [1:0] {IDLE, ISSUE, BUSY, RESP} state_t;

  state_t           state_q, state_d;
  logic             grant_q, grant_d;
  logic             lastGrant_q, lastGrant_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             pick;

  // On a tie the requester that did not win last time is served.
  assign pick = (i_req_valid == 2'b11) ? ~lastGrant_q : i_req_valid[1];

`ifdef MONT_ARB_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= IDLE;
      grant_q     <= 1'b0;
      lastGrant_q <= 1'b1;
      a_q         <= '0;
      b_q         <= '0;
      result_q    <= '0;
`ifdef MONT_ARB_TIMEOUT_EN
      cnt_q       <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      lastGrant_q <= lastGrant_d;
      a_q         <= a_d;
      b_q         <= b_d;
      result_q    <= result_d;
`ifdef MONT_ARB_TIMEOUT_EN
      cnt_q       <= cnt_d;
      err_q       <= err_d;
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    lastGrant_d  = lastGrant_q;
    a_d          = a_q;
    b_d          = b_q;
    result_d     = result_q;
    o_req_ready  = 2'b00;
    o_rsp_valid  = 2'b00;
    o_mont_start = 1'b0;
`ifdef MONT_ARB_TIMEOUT_EN
    cnt_d        = cnt_q;
    err_d        = err_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (|i_req_valid) begin
          o_req_ready = pick ? 2'b10 : 2'b01;
          a_d         = pick ? i_req_a1 : i_req_a0;
          b_d         = pick ? i_req_b1 : i_req_b0;
          grant_d     = pick;
          lastGrant_d = pick;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        o_mont_start = 1'b1;
`ifdef MONT_ARB_TIMEOUT_EN
        cnt_d        = '0;
`endif
        state_d      = BUSY;
      end
      BUSY: begin
        // A finish landing on the watchdog's last cycle still counts as success.
        if (i_mont_finished) begin
          result_d = i_mont_result;
`ifdef MONT_ARB_TIMEOUT_EN
          err_d    = 1'b0;
`endif
          state_d  = RESP;
`ifdef MONT_ARB_TIMEOUT_EN
        end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          result_d = '0;
          err_d    = 1'b1;
          state_d  = RESP;
        end else begin
          cnt_d    = cnt_q + CW'(1);
`endif
        end
      end
      RESP: begin
        o_rsp_valid = grant_q ? 2'b10 : 2'b01;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign o_mont_a     = a_q;
  assign o_mont_b     = b_q;
  assign o_rsp_result = result_q;
`ifdef MONT_ARB_TIMEOUT_EN
  assign o_rsp_err    = err_q;
`else
  assign o_rsp_err    = 1'b0;
`endif

endmodule

// File: tb/tb_mont_arbiter.sv
// Directed bench for mont_arbiter with an a+b multiplier stub finishing K cycles after start.
// Covers the MONT_ARB_TIMEOUT_EN build as well as the default one.
module tb_mont_arbiter;

  localparam int WIDTH   = 16;
  localparam int TIMEOUT = 10;
  localparam int K       = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [1:0]       reqValid = 2'b00;
  logic [WIDTH-1:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
  logic [1:0]       reqReady, rspValid;
  logic [WIDTH-1:0] rspResult, montA, montB;
  logic             rspErr, montStart;
  logic [WIDTH-1:0] stubResult = '0;
  logic             stubFin = 1'b0, strayFin = 1'b0, stubEnable = 1'b1;
  logic             montFinished;

  int cyc = 0;
  int vecCount = 0;
  int missCount = 0;

  assign montFinished = stubFin | strayFin;

  mont_arbiter #(.WIDTH(WIDTH), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .i_clk(clk), .i_rst(rst), .i_req_valid(reqValid),
    .i_req_a0(a0), .i_req_b0(b0), .i_req_a1(a1), .i_req_b1(b1),
    .o_req_ready(reqReady), .o_rsp_valid(rspValid), .o_rsp_result(rspResult),
    .o_rsp_err(rspErr), .o_mont_start(montStart), .o_mont_a(montA), .o_mont_b(montB),
    .i_mont_result(stubResult), .i_mont_finished(montFinished)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Multiplier stub: pulses finished K cycles after the start pulse, result = a + b.
  int               startCyc = 0;
  logic             pending = 1'b0;
  logic [WIDTH-1:0] sumLatched = '0;
  always @(negedge clk) begin
    if (rst) begin
      pending = 1'b0;
      stubFin = 1'b0;
    end else begin
      stubFin = 1'b0;
      if (pending && cyc == startCyc + K) begin
        stubFin    = stubEnable;
        stubResult = sumLatched;
        pending    = 1'b0;
      end
      if (montStart) begin
        pending    = 1'b1;
        startCyc   = cyc;
        sumLatched = montA + montB;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vecCount++;
    if (got !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic waitAccept(input logic [1:0] expReady, input string tag, output int acc);
    #1;
    for (int i = 0; i < 50 && reqReady == 2'b00; i++) begin
      @(negedge clk);
      #1;
    end
    checkOutput({tag, "_ready"}, 64'(reqReady), 64'(expReady));
    acc = cyc;
  endtask

  task automatic waitResponse(input logic [1:0] expValid, input logic [WIDTH-1:0] expResult,
                              input logic expErr, input int acc, input int expLat,
                              input int budget, input string tag);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #1;
      if (rspValid != 2'b00) break;
    end
    checkOutput({tag, "_valid"}, 64'(rspValid), 64'(expValid));
    checkOutput({tag, "_result"}, 64'(rspResult), 64'(expResult));
    checkOutput({tag, "_err"}, 64'(rspErr), 64'(expErr));
    checkOutput({tag, "_latency"}, 64'(cyc - acc), 64'(expLat));
  endtask

  task automatic applyStimulus(input logic [1:0] valid,
                               input logic [WIDTH-1:0] na0, input logic [WIDTH-1:0] nb0,
                               input logic [WIDTH-1:0] na1, input logic [WIDTH-1:0] nb1);
    a0 = na0; b0 = nb0; a1 = na1; b1 = nb1;
    reqValid = valid;
  endtask

  task automatic applyReset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  int acc, t0, t1, seen;

  initial begin
    @(negedge clk);
    #1;
    checkOutput("rst_ready", 64'(reqReady), 64'd0);
    checkOutput("rst_rspValid", 64'(rspValid), 64'd0);
    checkOutput("rst_start", 64'(montStart), 64'd0);
    checkOutput("rst_montA", 64'(montA), 64'd0);
    checkOutput("rst_result", 64'(rspResult), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Single request from requester 0.
    @(negedge clk);
    applyStimulus(2'b01, 16'd3, 16'd5, 16'd0, 16'd0);
    waitAccept(2'b01, "single", acc);
    @(negedge clk);
    #1;
    reqValid = 2'b00;
    checkOutput("single_start", 64'(montStart), 64'd1);
    checkOutput("single_montA", 64'(montA), 64'd3);
    checkOutput("single_montB", 64'(montB), 64'd5);
    waitResponse(2'b01, 16'd8, 1'b0, acc, K + 2, 50, "single");
    @(negedge clk);
    #1;
    checkOutput("single_pulseEnds", 64'(rspValid), 64'd0);
    checkOutput("single_resultHeld", 64'(rspResult), 64'd8);

    // Tie straight after reset, then strict alternation with both held.
    applyReset();
    applyStimulus(2'b11, 16'd1, 16'd1, 16'd10, 16'd20);
    waitAccept(2'b01, "tie0", t0);
    waitResponse(2'b01, 16'd2, 1'b0, t0, K + 2, 50, "tie0");
    waitAccept(2'b10, "tie1", t1);
    checkOutput("tie_spacing", 64'(t1 - t0), 64'(K + 3));
    waitResponse(2'b10, 16'd30, 1'b0, t1, K + 2, 50, "tie1");
    for (int i = 0; i < 6; i++) begin
      waitAccept((i % 2 == 0) ? 2'b01 : 2'b10, $sformatf("fair%0d", i), acc);
      waitResponse((i % 2 == 0) ? 2'b01 : 2'b10, (i % 2 == 0) ? 16'd2 : 16'd30,
                   1'b0, acc, K + 2, 50, $sformatf("fair%0d", i));
    end
    reqValid = 2'b00;

    // Stray finished pulses in IDLE and ISSUE are ignored.
    @(negedge clk);
    strayFin = 1'b1;
    @(negedge clk);
    strayFin = 1'b0;
    #1;
    checkOutput("strayIdle_rspValid", 64'(rspValid), 64'd0);
    checkOutput("strayIdle_start", 64'(montStart), 64'd0);
    @(negedge clk);
    #1;
    checkOutput("strayIdle_rspValid2", 64'(rspValid), 64'd0);
    applyStimulus(2'b01, 16'd4, 16'd6, 16'd0, 16'd0);
    waitAccept(2'b01, "stray", acc);
    @(negedge clk);
    #1;
    reqValid = 2'b00;
    checkOutput("strayIssue_start", 64'(montStart), 64'd1);
    strayFin = 1'b1;
    @(negedge clk);
    strayFin = 1'b0;
    #1;
    checkOutput("strayIssue_rspValid", 64'(rspValid), 64'd0);
    waitResponse(2'b01, 16'd10, 1'b0, acc, K + 2, 50, "stray");

    // Reset in the middle of BUSY aborts the request without a response.
    @(negedge clk);
    applyStimulus(2'b01, 16'd2, 16'd2, 16'd0, 16'd0);
    waitAccept(2'b01, "abort", acc);
    @(negedge clk);
    #1;
    reqValid = 2'b00;
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("abort_rspValid", 64'(rspValid), 64'd0);
    checkOutput("abort_start", 64'(montStart), 64'd0);
    checkOutput("abort_montA", 64'(montA), 64'd0);
    checkOutput("abort_montB", 64'(montB), 64'd0);
    checkOutput("abort_result", 64'(rspResult), 64'd0);
    @(negedge clk);
    #2;
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      if (rspValid != 2'b00) seen++;
    end
    checkOutput("abort_noResponse", 64'(seen), 64'd0);
    applyStimulus(2'b10, 16'd0, 16'd0, 16'd7, 16'd9);
    waitAccept(2'b10, "afterAbort", acc);
    @(negedge clk);
    #1;
    reqValid = 2'b00;
    waitResponse(2'b10, 16'd16, 1'b0, acc, K + 2, 50, "afterAbort");

    // Multiplier that never finishes.
    stubEnable = 1'b0;
    @(negedge clk);
    applyStimulus(2'b01, 16'd5, 16'd5, 16'd0, 16'd0);
    waitAccept(2'b01, "hang", acc);
    @(negedge clk);
    #1;
    reqValid = 2'b00;
`ifdef MONT_ARB_TIMEOUT_EN
    waitResponse(2'b01, 16'd0, 1'b1, acc, TIMEOUT + 2, 100, "timeout");
`else
    seen = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      #1;
      if (rspValid != 2'b00) seen++;
    end
    checkOutput("hang_noResponse", 64'(seen), 64'd0);
    checkOutput("hang_err", 64'(rspErr), 64'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
